dropout_lfsr_unit: RTL and testbench

- Synthesizable, parametrised dropout stage for the neuron datapath.
- Takes a vector of LANES neuron values over a valid/ready stream and zeroes each lane with a programmable probability.
- Each lane draws its randomness from its own on-chip LFSR.
- Sits between a weight/activation producer and the downstream accumulator; bypassed in inference mode via train_en.

---
 rtl/dropout_lfsr_unit.sv | 127 ++++++++++++
 tb/tb_dropout_lfsr_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dropout_lfsr_unit.sv
// Dropout stage: zeroes each lane when its per-lane LFSR byte is below cfg_rate.
// Define DROPOUT_SCALE_EN to enable inverted-dropout scaling of kept lanes.
module dropout_lfsr_unit #(
  parameter int          LANES    = 8,
  parameter int          DATA_W   = 8,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          SCALE_SH = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      train_en,
  input  logic [7:0]                cfg_rate,
  input  logic                      seed_load,
  input  logic                      cnt_clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [LANES-1:0]          out_mask,
  output logic [15:0]               drop_count
);

  localparam logic [15:0] TAPS = 16'hB400;
`ifdef DROPOUT_SCALE_EN
  localparam int SHIFT = SCALE_SH;
`else
  // SCALE_SH has no effect unless scaling is built in
  localparam int SHIFT = 0 * SCALE_SH;
`endif

  logic                    accept;
  logic [LANES-1:0]        keep;
  logic [LANES*DATA_W-1:0] lane_val;

  logic                    out_valid_q, out_valid_d;
  logic [LANES*DATA_W-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]        out_mask_q, out_mask_d;
  logic [15:0]             drop_count_q, drop_count_d;
  logic [16:0]             drop_sum;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [15:0] RAW_SEED  = SEED ^ 16'(gi * 16'h1F35);
      localparam logic [15:0] LANE_SEED = (RAW_SEED == 16'h0000) ? 16'h0001 : RAW_SEED;

      logic [15:0]         lfsr_q, lfsr_d;
      logic [DATA_W-1:0]   din;
      logic [2*DATA_W-1:0] wide;
      logic [DATA_W-1:0]   scaled;

      assign din    = in_data[gi*DATA_W +: DATA_W];
      assign wide   = {{DATA_W{1'b0}}, din} << SHIFT;
      assign scaled = (|wide[2*DATA_W-1:DATA_W]) ? '1 : wide[DATA_W-1:0];

      // Inference mode keeps every lane untouched
      assign keep[gi] = !train_en || (lfsr_q[7:0] >= cfg_rate);
      assign lane_val[gi*DATA_W +: DATA_W] = !train_en ? din : (keep[gi] ? scaled : '0);

      always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load) begin
          lfsr_d = LANE_SEED;
        end else if (accept && train_en) begin
          lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lfsr_q <= LANE_SEED;
        end else begin
          lfsr_q <= lfsr_d;
        end
      end
    end
  endgenerate

  always_comb begin
    drop_sum = {1'b0, drop_count_q};
    for (int i = 0; i < LANES; i++) begin
      drop_sum = drop_sum + 17'(!keep[i]);
    end

    drop_count_d = drop_count_q;
    if (cnt_clr) begin
      drop_count_d = '0;
    end else if (accept) begin
      drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mask_d  = out_mask_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = lane_val;
      out_mask_d  = keep;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_mask_q   <= '0;
      drop_count_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_mask_q   <= out_mask_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_mask   = out_mask_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_dropout_lfsr_unit.sv
// Scoreboard bench for dropout_lfsr_unit: stimulus pushes expected beats, a monitor pops them.
module tb_dropout_lfsr_unit;
  localparam int LANES = 8;
  localparam int DW    = 8;
  localparam int W     = LANES * DW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           train_en = 1'b0;
  logic [7:0]     cfg_rate = 8'h00;
  logic           seed_load = 1'b0;
  logic           cnt_clr = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic [LANES-1:0] out_mask;
  logic [15:0]    drop_count;

  int total = 0;
  int bad   = 0;
  int beat_no = 0;

  typedef struct packed {
    logic [W-1:0]     data;
    logic [LANES-1:0] mask;
  } beat_t;
  beat_t expq[$];

  dropout_lfsr_unit #(
    .LANES(LANES), .DATA_W(DW), .SEED(16'hACE1), .SCALE_SH(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .train_en(train_en), .cfg_rate(cfg_rate),
    .seed_load(seed_load), .cnt_clr(cnt_clr), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] scl(input logic [DW-1:0] x);
`ifdef DROPOUT_SCALE_EN
    logic [DW:0] w;
    w = {x, 1'b0};
    return w[DW] ? {DW{1'b1}} : w[DW-1:0];
`else
    return x;
`endif
  endfunction

  function automatic logic [W-1:0] build_exp(input logic [W-1:0] d, input logic [7:0] m,
                                             input logic tr);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      if (m[i]) r[i*DW +: DW] = tr ? scl(d[i*DW +: DW]) : d[i*DW +: DW];
    end
    return r;
  endfunction

  // Holds the beat until in_ready is seen at a falling edge; acceptance is the next rising edge.
  task automatic send(input logic [W-1:0] d, input logic tr, input logic [7:0] rate,
                      input logic sl, input logic [W-1:0] ed, input logic [7:0] em);
    int n;
    beat_t b;
    n = 0;
    in_data = d; train_en = tr; cfg_rate = rate; seed_load = sl; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: got in_ready=0 expected 1");
      in_valid = 1'b0; seed_load = 1'b0;
      return;
    end
    b.data = ed; b.mask = em;
    expq.push_back(b);
    @(posedge clk); #1;
    in_valid = 1'b0; seed_load = 1'b0;
  endtask

  task automatic seed_pulse();
    seed_load = 1'b1;
    @(posedge clk); #1;
    seed_load = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      beat_t e;
      total++;
      beat_no++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat %0d: got data=%h mask=%h expected none", beat_no, out_data, out_mask);
      end else begin
        e = expq.pop_front();
        if (out_data !== e.data || out_mask !== e.mask) begin
          bad++;
          $display("FAIL beat %0d: got data=%h mask=%h expected data=%h mask=%h",
                   beat_no, out_data, out_mask, e.data, e.mask);
        end else begin
          $display("beat %0d ok data=%h mask=%h", beat_no, out_data, out_mask);
        end
      end
    end
  end

  initial begin
    logic [W-1:0] d, dr, d6, e6;
    d  = {8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h5A};
    d6 = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h90, 8'h5A};
`ifdef DROPOUT_SCALE_EN
    e6 = {8'h02, 8'h04, 8'h06, 8'h08, 8'h0A, 8'h0C, 8'hFF, 8'hB4};
`else
    e6 = d6;
`endif

    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_mask", out_mask, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Stalled beat, then reset mid-stream
    send(d, 1'b1, 8'h80, 1'b0, build_exp(d, 8'hE7, 1'b1), 8'hE7);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_in_ready", in_ready, 0);
    chk("cnt_first", drop_count, 2);
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_mask", out_mask, 0);
    chk("midrst_drop_count", drop_count, 0);
    chk("midrst_in_ready", in_ready, 1);
    expq.delete();
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;

    // Lane sequence from seed state
    send(d, 1'b1, 8'h80, 1'b0, build_exp(d, 8'hE7, 1'b1), 8'hE7);
    send(d, 1'b1, 8'h80, 1'b0, build_exp(d, 8'h4A, 1'b1), 8'h4A);
    chk("cnt_seq", drop_count, 7);

    // Seed reload restarts the sequence
    seed_pulse();
    send(d, 1'b1, 8'h80, 1'b0, build_exp(d, 8'hE7, 1'b1), 8'hE7);
    chk("cnt_reload", drop_count, 9);

    // Backpressure
    seed_pulse();
    out_ready = 1'b0;
    send(d, 1'b1, 8'h80, 1'b0, build_exp(d, 8'hE7, 1'b1), 8'hE7);
    chk("bp_in_ready", in_ready, 0);
    fork
      send(d, 1'b1, 8'h80, 1'b0, build_exp(d, 8'h4A, 1'b1), 8'h4A);
      begin
        repeat (5) begin
          @(posedge clk); #2;
          chk("bp_hold_data", out_data, build_exp(d, 8'hE7, 1'b1));
          chk("bp_hold_mask", out_mask, 8'hE7);
          chk("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
      end
    join
    chk("cnt_bp", drop_count, 16);

    // Rate 0 never drops
    for (int k = 0; k < 100; k++) begin
      dr = {$urandom, $urandom};
      send(dr, 1'b1, 8'h00, 1'b0, build_exp(dr, 8'hFF, 1'b1), 8'hFF);
    end
    chk("cnt_rate0", drop_count, 16);

    // Load coinciding with accept: beat uses old state, load wins over advance
    seed_pulse();
    send(d, 1'b1, 8'h80, 1'b1, build_exp(d, 8'hE7, 1'b1), 8'hE7);
    send(d, 1'b1, 8'hFF, 1'b0, build_exp(d, 8'h00, 1'b1), 8'h00);
    chk("cnt_rateff", drop_count, 26);

    // Clear beats a simultaneous increment
    cnt_clr = 1'b1;
    send(d, 1'b1, 8'hFF, 1'b0, build_exp(d, 8'h00, 1'b1), 8'h00);
    cnt_clr = 1'b0;
    chk("cnt_clr_wins", drop_count, 0);

    // Inference pass-through leaves LFSRs and count alone
    seed_pulse();
    send(d, 1'b0, 8'hFF, 1'b0, d, 8'hFF);
    chk("cnt_infer", drop_count, 0);
    send(d, 1'b1, 8'h80, 1'b0, build_exp(d, 8'hE7, 1'b1), 8'hE7);
    chk("cnt_after_infer", drop_count, 2);

    // Scaling / saturation vector
    send(d6, 1'b1, 8'h00, 1'b0, e6, 8'hFF);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
